// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: owns the framebuffer port; scan-out reads take fixed slots, receiver writes fill the rest.
module vga_fb_arbiter #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int SCALE = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 15,
  parameter logic [DATA_W-1:0] BORDER = '0
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [9:0]        h_count,
  input  logic [9:0]        v_count,
  input  logic              display_en,
  input  logic              frame_start,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              frame_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pixel_out
);
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
  localparam int SH = $clog2(SCALE);
  localparam logic [31:0] IW = 32'(IMG_W);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_W * IMG_H - 1);
  state_t state_q;
  logic [ADDR_W-1:0] wr_addr_q, rd_addr;
  logic [9:0] x, y;
  logic in_img, rd_req, accept;
  logic rd_q, en_q, in_img_q;
  logic [DATA_W-1:0] hold_q, pixel_q;
  assign x = h_count >> SH;
  assign y = v_count >> SH;
  assign in_img = 32'(x) < IMG_W && 32'(y) < IMG_H;
  assign rd_req = display_en && in_img && (h_count & 10'(SCALE - 1)) == '0;
  // y*IMG_W as a sum of shifted copies of y, one per set bit of IMG_W
  always_comb begin
    rd_addr = ADDR_W'(x);
    for (int i = 0; i < 32; i++)
      rd_addr = IW[i] ? rd_addr + ADDR_W'(32'(y) << i) : rd_addr;
  end
  assign wr_ready = !reset && state_q == STREAM && !rd_req;
  assign accept = wr_valid && wr_ready;
  assign frame_done = state_q == DONE;
  assign mem_addr = rd_req ? rd_addr : wr_addr_q;
  assign mem_we = accept;
  assign mem_wdata = wr_data;
  assign pixel_out = pixel_q;
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= IDLE;
      wr_addr_q <= '0;
    end else if (frame_start) begin
      state_q <= STREAM;
      wr_addr_q <= '0;
    end else if (state_q == DONE) begin
      state_q <= IDLE;
    end else if (accept) begin
      state_q <= wr_addr_q == LAST ? DONE : STREAM;
      wr_addr_q <= wr_addr_q == LAST ? '0 : wr_addr_q + ADDR_W'(1);
    end
  end
  // RAM data arrives one cycle after the read slot; the hold register replicates it across SCALE pixels
  always_ff @(posedge clk_in) begin
    if (reset) begin
      rd_q <= 1'b0;
      en_q <= 1'b0;
      in_img_q <= 1'b0;
      hold_q <= '0;
      pixel_q <= '0;
    end else begin
      rd_q <= rd_req;
      en_q <= display_en;
      in_img_q <= in_img;
      hold_q <= rd_q ? mem_rdata : hold_q;
      pixel_q <= !en_q ? '0 : (in_img_q ? (rd_q ? mem_rdata : hold_q) : BORDER);
    end
  end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed checks of scan-out, write interleaving, frame restart and reset.
module tb_vga_fb_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [9:0] h_count = '0, v_count = '0;
  logic display_en = 1'b0, frame_start = 1'b0, wr_valid = 1'b0;
  logic [7:0] wr_data = '0;
  logic wr_ready, frame_done, mem_we;
  logic [14:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata, pixel_out;
  logic b_wr_ready, b_frame_done, b_mem_we;
  logic [3:0] b_mem_addr;
  logic [7:0] b_mem_wdata, b_pixel;
  logic [7:0] b_rdata = 8'h3C;
  logic fill = 1'b0, fill_pat = 1'b0;
  logic [7:0] ram [0:32767];
  logic [7:0] sent [0:19199];
  int checks = 0, errors = 0;
  int h, v, c, nxt, bad, rbad, dcnt, dcyc, last, acc, ph, m;
  logic strm, exp_rdy, rs, wv;
  logic [7:0] wd, e0, e1;

  always #5 clk = ~clk;

  vga_fb_arbiter dut (
    .clk_in(clk), .reset(reset), .h_count(h_count), .v_count(v_count),
    .display_en(display_en), .frame_start(frame_start), .wr_valid(wr_valid),
    .wr_data(wr_data), .wr_ready(wr_ready), .frame_done(frame_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pixel_out(pixel_out)
  );

  vga_fb_arbiter #(.IMG_W(5), .IMG_H(3), .SCALE(2), .DATA_W(8), .ADDR_W(4), .BORDER(8'h5A)) dut_b (
    .clk_in(clk), .reset(reset), .h_count(h_count), .v_count(v_count),
    .display_en(display_en), .frame_start(1'b0), .wr_valid(1'b0),
    .wr_data(8'h00), .wr_ready(b_wr_ready), .frame_done(b_frame_done),
    .mem_addr(b_mem_addr), .mem_we(b_mem_we), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_rdata), .pixel_out(b_pixel)
  );

  always @(posedge clk) begin
    if (fill) for (int i = 0; i < 32768; i++) ram[i] <= fill_pat ? 8'(i) : 8'h00;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int hh, input int vv, input logic fs, input logic wvl,
                       input logic [7:0] wdl, input logic rst);
    @(negedge clk);
    h_count = 10'(hh);
    v_count = 10'(vv);
    display_en = hh < 640 && vv < 480;
    frame_start = fs;
    wr_valid = wvl;
    wr_data = wdl;
    reset = rst;
    #1;
  endtask

  task automatic fill_ram(input logic pat);
    @(negedge clk);
    fill = 1'b1;
    fill_pat = pat;
    @(negedge clk);
    fill = 1'b0;
  endtask

  initial begin
    fill_ram(1'b0);
    for (int i = 0; i < 3; i++) drive(0, 0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("rst_pixel", int'(pixel_out), 0);
    chk("rst_ready", int'(wr_ready), 0);
    chk("rst_done", int'(frame_done), 0);
    chk("rst_we", int'(mem_we), 0);
    bad = 0; rbad = 0; m = 0;
    for (int l = 0; l < 4; l++)
      for (int hh = 0; hh < 800; hh++) begin
        drive(hh, l < 2 ? l : 477 + l, 1'b0, 1'b1, 8'hFF, 1'b0);
        if (mem_we) bad++;
        if (wr_ready) rbad++;
        if (pixel_out != 8'h00) m++;
      end
    chk("idle_we", bad, 0);
    chk("idle_ready", rbad, 0);
    chk("idle_pixel", m, 0);

    fill_ram(1'b1);
    drive(8, 4, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("rd_addr_x2y1", int'(mem_addr), 162);
    drive(9, 4, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(10, 4, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("pix_h8", int'(pixel_out), 8'hA2);
    drive(11, 4, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("pix_hold1", int'(pixel_out), 8'hA2);
    drive(12, 4, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("pix_hold2", int'(pixel_out), 8'hA2);
    chk("rd_addr_x3y1", int'(mem_addr), 163);
    drive(13, 4, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("pix_hold3", int'(pixel_out), 8'hA2);
    drive(14, 4, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("pix_h12", int'(pixel_out), 8'hA3);
    bad = 0; e0 = 0; e1 = 0;
    for (int k = 0; k < 802; k++) begin
      drive(k % 800, k < 800 ? 477 : 478, 1'b0, 1'b0, 8'h00, 1'b0);
      if (k >= 2 && pixel_out != e1) bad++;
      e1 = e0;
      e0 = k < 640 ? 8'(119 * 160 + k / 4) : 8'h00;
    end
    chk("scan_last_row", bad, 0);

    drive(6, 4, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("b_rd_addr", int'(b_mem_addr), 13);
    drive(7, 4, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(10, 4, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("b_pix_read", int'(b_pixel), 8'h3C);
    drive(11, 4, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("b_pix_hold", int'(b_pixel), 8'h3C);
    drive(12, 4, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("b_pix_border", int'(b_pixel), 8'h5A);
    drive(700, 4, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(700, 4, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(700, 4, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("b_pix_blank", int'(b_pixel), 0);
    chk("b_idle", int'({b_wr_ready, b_mem_we, b_frame_done}) + int'(b_mem_wdata), 0);

    h = 0; v = 0; nxt = 0; bad = 0; rbad = 0; dcnt = 0; dcyc = -10; last = -1; strm = 1'b0;
    for (c = 0; c < 30000 && !(dcnt > 0 && c > dcyc + 4); c++) begin
      drive(h, v, c == 0, 1'b1, 8'hC3, 1'b0);
      exp_rdy = strm && !(h < 640 && v < 480 && h % 4 == 0);
      if (wr_ready !== exp_rdy) rbad++;
      if (mem_we) begin
        if (int'(mem_addr) != nxt) bad++;
        if (nxt == 19199) begin last = c; strm = 1'b0; end
        nxt++;
      end
      if (frame_done) begin dcnt++; dcyc = c; end
      if (c == 0) strm = 1'b1;
      h++;
      if (h == 800) begin h = 0; v = (v + 1) % 525; end
    end
    chk("seq_gaps", bad, 0);
    chk("seq_count", nxt, 19200);
    chk("ready_rule", rbad, 0);
    chk("done_pulses", dcnt, 1);
    chk("done_latency", dcyc - last, 1);

    drive(700, 500, 1'b1, 1'b0, 8'h00, 1'b0);
    nxt = 0; bad = 0; ph = 0; acc = 0; dcnt = 0; dcyc = -10; last = -1;
    for (c = 0; c < 60000 && !(dcnt > 0 && c > dcyc + 3); c++) begin
      rs = ph == 0 && nxt == 1000;
      wv = rs ? 1'b1 : 1'($urandom_range(0, 1));
      wd = 8'($urandom);
      drive(700, 500, rs, wv, wd, 1'b0);
      if (rs) chk("restart_write", mem_we ? int'(mem_addr) : -1, 1000);
      if (mem_we) begin
        if (int'(mem_addr) != nxt) bad++;
        if (ph == 1 && acc == 0) chk("restart_first", int'(mem_addr), 0);
        if (ph == 1) begin
          if (nxt < 19200) sent[nxt] = wd;
          acc++;
          if (nxt == 19199) last = c;
        end
        nxt = rs ? 0 : nxt + 1;
        if (rs) ph = 1;
      end
      if (frame_done) begin dcnt++; dcyc = c; end
    end
    chk("thr_seq", bad, 0);
    chk("thr_count", acc, 19200);
    chk("thr_done", dcnt, 1);
    chk("thr_done_lat", dcyc - last, 1);
    m = 0;
    for (int i = 0; i < 19200; i++) if (ram[i] !== sent[i]) m++;
    chk("ram_image", m, 0);

    drive(700, 500, 1'b1, 1'b0, 8'h00, 1'b0);
    nxt = 0; c = 0;
    while (nxt < 500 && c < 2000) begin
      drive(700, 500, 1'b0, 1'b1, 8'h11, 1'b0);
      if (mem_we) nxt++;
      c++;
    end
    drive(700, 500, 1'b0, 1'b1, 8'h22, 1'b1);
    drive(700, 500, 1'b0, 1'b1, 8'h22, 1'b0);
    chk("rst_mid_ready", int'(wr_ready), 0);
    chk("rst_mid_we", int'(mem_we), 0);
    drive(700, 500, 1'b0, 1'b1, 8'h22, 1'b0);
    chk("rst_mid_idle", int'(wr_ready), 0);
    drive(700, 500, 1'b1, 1'b1, 8'h33, 1'b0);
    chk("rst_fs_cycle", int'(mem_we), 0);
    drive(700, 500, 1'b0, 1'b1, 8'h44, 1'b0);
    chk("rst_restart_a0", mem_we ? int'(mem_addr) : -1, 0);
    drive(700, 500, 1'b0, 1'b1, 8'h55, 1'b0);
    chk("rst_restart_a1", mem_we ? int'(mem_addr) : -1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
